// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, frame-format encodings, oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  localparam logic STOP_BITS_1 = 1'b0;
  localparam logic STOP_BITS_2 = 1'b1;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(7);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  // Bit index of the final data bit for a given length encoding.
  function automatic logic [IDX_W-1:0] last_index(input logic [1:0] bits);
    logic [IDX_W-1:0] idx;
    case (bits)
      DATA_BITS_5: idx = IDX_W'(4);
      DATA_BITS_6: idx = IDX_W'(5);
      DATA_BITS_7: idx = IDX_W'(6);
      DATA_BITS_8: idx = IDX_W'(7);
      default:     idx = IDX_W'(7);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_synchronizer (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled de-serialiser producing a byte, valid pulse and error flags.
// Optional parity support is built when UART_PARITY_EN is defined.
module uart_receiver
  import uart_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rx_i,
  input  logic              sample_i,
  input  logic [1:0]        data_bits_i,
  input  logic              stop_bits_i,
`ifdef UART_PARITY_EN
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  output logic              parity_error_o,
`endif
  output logic [BYTE_W-1:0] data_o,
  output logic              valid_o,
  output logic              frame_error_o,
  output logic              busy_o
);

  logic w_rx_s;

  uart_rx_synchronizer u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (w_rx_s)
  );

  rx_state_e           r_state,     w_state_nxt;
  logic [TICK_W-1:0]   r_tick,      w_tick_nxt;
  logic [IDX_W-1:0]    r_idx,       w_idx_nxt;
  logic [BYTE_W-1:0]   r_shift,     w_shift_nxt;
  logic                r_ferr,      w_ferr_nxt;
  logic                r_second,    w_second_nxt;
  logic                r_armed,     w_armed_nxt;
  logic [1:0]          r_cfg_bits,  w_cfg_bits_nxt;
  logic                r_cfg_stop,  w_cfg_stop_nxt;
  logic [BYTE_W-1:0]   w_data_nxt;
  logic                w_valid_nxt;
  logic                w_ferr_out_nxt;
  logic                w_busy_nxt;
  logic                w_last_tick;
  logic                w_stop_err;
`ifdef UART_PARITY_EN
  logic                r_cfg_par_en,  w_cfg_par_en_nxt;
  logic                r_cfg_par_odd, w_cfg_par_odd_nxt;
  logic                r_perr,        w_perr_nxt;
  logic                w_perr_out_nxt;
`endif

  assign w_last_tick = sample_i && (r_tick == TICK_LAST);
  assign w_stop_err  = r_ferr | ~w_rx_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_ferr_nxt     = r_ferr;
    w_second_nxt   = r_second;
    w_armed_nxt    = r_armed;
    w_cfg_bits_nxt = r_cfg_bits;
    w_cfg_stop_nxt = r_cfg_stop;
    w_data_nxt     = data_o;
    w_valid_nxt    = 1'b0;
    w_ferr_out_nxt = 1'b0;
`ifdef UART_PARITY_EN
    w_cfg_par_en_nxt  = r_cfg_par_en;
    w_cfg_par_odd_nxt = r_cfg_par_odd;
    w_perr_nxt        = r_perr;
    w_perr_out_nxt    = 1'b0;
`endif

    if (sample_i) w_tick_nxt = r_tick + TICK_W'(1);

    case (r_state)
      ST_IDLE: begin
        // Re-arm only after a high level, so a held break cannot retrigger.
        if (w_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (sample_i && r_armed) begin
          w_state_nxt    = ST_START;
          w_tick_nxt     = '0;
          w_cfg_bits_nxt = data_bits_i;
          w_cfg_stop_nxt = stop_bits_i;
`ifdef UART_PARITY_EN
          w_cfg_par_en_nxt  = parity_en_i;
          w_cfg_par_odd_nxt = parity_odd_i;
`endif
        end
      end

      ST_START: begin
        if (sample_i && (r_tick == TICK_MID)) begin
          if (!w_rx_s) begin
            w_state_nxt  = ST_DATA;
            w_tick_nxt   = '0;
            w_idx_nxt    = '0;
            w_shift_nxt  = '0;
            w_ferr_nxt   = 1'b0;
            w_second_nxt = 1'b0;
`ifdef UART_PARITY_EN
            w_perr_nxt   = 1'b0;
`endif
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (w_last_tick) begin
          w_shift_nxt[r_idx] = w_rx_s;
          w_idx_nxt          = r_idx + IDX_W'(1);
          if (r_idx == last_index(r_cfg_bits)) begin
`ifdef UART_PARITY_EN
            w_state_nxt = r_cfg_par_en ? ST_PARITY : ST_STOP;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_last_tick) begin
          w_perr_nxt  = (^r_shift) ^ w_rx_s ^ r_cfg_par_odd;
          w_state_nxt = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (w_last_tick) begin
          w_ferr_nxt = w_stop_err;
          if ((r_cfg_stop == STOP_BITS_2) && !r_second) begin
            w_second_nxt = 1'b1;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_data_nxt     = r_shift;
            w_valid_nxt    = 1'b1;
            w_ferr_out_nxt = w_stop_err;
`ifdef UART_PARITY_EN
            w_perr_out_nxt = r_perr;
`endif
            if (w_stop_err) w_armed_nxt = 1'b0;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tick        <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_ferr        <= 1'b0;
      r_second      <= 1'b0;
      r_armed       <= 1'b1;
      r_cfg_bits    <= DATA_BITS_8;
      r_cfg_stop    <= STOP_BITS_1;
      data_o        <= '0;
      valid_o       <= 1'b0;
      frame_error_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      r_tick        <= w_tick_nxt;
      r_idx         <= w_idx_nxt;
      r_shift       <= w_shift_nxt;
      r_ferr        <= w_ferr_nxt;
      r_second      <= w_second_nxt;
      r_armed       <= w_armed_nxt;
      r_cfg_bits    <= w_cfg_bits_nxt;
      r_cfg_stop    <= w_cfg_stop_nxt;
      data_o        <= w_data_nxt;
      valid_o       <= w_valid_nxt;
      frame_error_o <= w_ferr_out_nxt;
      busy_o        <= w_busy_nxt;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cfg_par_en   <= 1'b0;
      r_cfg_par_odd  <= 1'b0;
      r_perr         <= 1'b0;
      parity_error_o <= 1'b0;
    end else begin
      r_cfg_par_en   <= w_cfg_par_en_nxt;
      r_cfg_par_odd  <= w_cfg_par_odd_nxt;
      r_perr         <= w_perr_nxt;
      parity_error_o <= w_perr_out_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_receiver;

  localparam int BIT_CYC = 64;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       rx_i;
  logic       sample_i;
  logic [1:0] data_bits_i;
  logic       stop_bits_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       parity_error_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_error_o;
  logic       busy_o;

  int   total = 0;
  int   bad   = 0;
  rec_t q[$];
  rec_t got, exp_r;
  int   early;
  int   gap;

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .rx_i           (rx_i),
    .sample_i       (sample_i),
    .data_bits_i    (data_bits_i),
    .stop_bits_i    (stop_bits_i),
`ifdef UART_PARITY_EN
    .parity_en_i    (parity_en_i),
    .parity_odd_i   (parity_odd_i),
    .parity_error_o (parity_error_o),
`endif
    .data_o         (data_o),
    .valid_o        (valid_o),
    .frame_error_o  (frame_error_o),
    .busy_o         (busy_o)
  );

`ifndef UART_PARITY_EN
  assign parity_error_o = 1'b0;
`endif

  // Baud divider 3: one tick every fourth cycle.
  initial begin
    sample_i = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_i = 1'b1;
      @(negedge clk);
      sample_i = 1'b0;
    end
  end

  // Capture every completed frame.
  initial begin
    forever begin
      @(negedge clk);
      if (valid_o) q.push_back('{d: data_o, fe: frame_error_o, pe: parity_error_o});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: what the receiver must report for the bits put on the line.
  function automatic rec_t model(input logic [7:0] d, input logic [1:0] db, input logic sb,
                                 input logic pen, input logic pod, input logic pbit,
                                 input logic s1, input logic s2);
    rec_t r;
    int   n;
    n    = int'(db) + 5;
    r.d  = d & 8'((1 << n) - 1);
    r.fe = !s1 || (sb && !s2);
    r.pe = pen && ((($countones(r.d) + int'(pbit)) % 2) != int'(pod));
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic sb,
                            input logic pen, input logic pod, input logic pbit,
                            input logic s1, input logic s2, output int early_cnt);
    data_bits_i  = db;
    stop_bits_i  = sb;
    parity_en_i  = pen;
    parity_odd_i = pod;
    rx_i = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < int'(db) + 5; i++) begin
      rx_i = d[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    if (pen) begin
      rx_i = pbit;
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_i = s1;
    repeat (BIT_CYC) @(negedge clk);
    early_cnt = q.size();
    if (sb) begin
      rx_i = s2;
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic check_frame(input string tag, input rec_t e, input logic sb, input int early_cnt);
    chk({tag, "_early"}, 32'(early_cnt), sb ? 32'd0 : 32'd1);
    chk({tag, "_count"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      got = q.pop_front();
      chk({tag, "_data"}, 32'(got.d), 32'(e.d));
      chk({tag, "_ferr"}, 32'(got.fe), 32'(e.fe));
`ifdef UART_PARITY_EN
      chk({tag, "_perr"}, 32'(got.pe), 32'(e.pe));
`endif
    end
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    q.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] db,
                           input logic sb, input logic pen, input logic pod, input logic pbit,
                           input logic s1, input logic s2);
    rec_t e;
    int   ec;
    q.delete();
    e = model(d, db, sb, pen, pod, pbit, s1, s2);
    send_frame(d, db, sb, pen, pod, pbit, s1, s2, ec);
    repeat (2) @(negedge clk);
    check_frame(tag, e, sb, ec);
  endtask

  initial begin
    rst_n_i = 1'b0; rx_i = 1'b1; data_bits_i = 2'b11; stop_bits_i = 1'b0;
    parity_en_i = 1'b0; parity_odd_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data",  32'(data_o), 32'h00);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ferr",  32'(frame_error_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    rst_n_i = 1'b1;
    repeat (20) @(negedge clk);

    run_frame("8n1_a5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    run_frame("7n2_5a", 8'h5A, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    run_frame("7n2_bad2", 8'h5A, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);

    // Short low glitch must be rejected at the start-bit midpoint.
    q.delete();
    rx_i = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy_o), 32'd1);
    repeat (8) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy_o), 32'd0);
    chk("glitch_novalid", 32'(q.size()), 32'd0);

    // Break: two frame times low gives exactly one errored all-zero frame.
    data_bits_i = 2'b11; stop_bits_i = 1'b0;
    rx_i = 1'b0;
    repeat (20 * BIT_CYC) @(negedge clk);
    chk("break_count", 32'(q.size()), 32'd1);
    if (q.size() > 0) begin
      got = q.pop_front();
      chk("break_data", 32'(got.d), 32'h00);
      chk("break_ferr", 32'(got.fe), 32'd1);
    end
    chk("break_busy", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    run_frame("after_break", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef UART_PARITY_EN
    repeat (10) @(negedge clk);
    run_frame("par_ok",  8'h07, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    run_frame("par_bad", 8'h07, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    repeat (10) @(negedge clk);

    // Reset during data bit 3 aborts the frame and clears every output.
    q.delete();
    data_bits_i = 2'b11; stop_bits_i = 1'b0;
    rx_i = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_i = (i == 0);
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_busy", 32'(busy_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_data",  32'(data_o), 32'h00);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_ferr",  32'(frame_error_o), 32'd0);
    chk("mid_rst_perr",  32'(parity_error_o), 32'd0);
    chk("mid_rst_busy",  32'(busy_o), 32'd0);
    @(negedge clk);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n_i = 1'b1;
    repeat (BIT_CYC * 12) @(negedge clk);
    chk("mid_no_valid", 32'(q.size()), 32'd0);
    run_frame("after_rst", 8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized frames with random format, occasional bad stop bits and parity.
    for (int k = 0; k < 14; k++) begin
      logic [7:0] d;
      logic [1:0] db;
      logic sb, pen, pod, pbit, s1, s2;
      d    = 8'($urandom);
      db   = 2'($urandom);
      sb   = 1'($urandom);
      pen  = 1'b0;
      pod  = 1'b0;
      pbit = 1'b0;
`ifdef UART_PARITY_EN
      pen  = 1'($urandom);
      pod  = 1'($urandom);
      pbit = 1'($urandom);
`endif
      s1   = ($urandom_range(0, 5) != 0);
      s2   = ($urandom_range(0, 5) != 0);
      exp_r = model(d, db, sb, pen, pod, pbit, s1, s2);
      q.delete();
      send_frame(d, db, sb, pen, pod, pbit, s1, s2, early);
      repeat (2) @(negedge clk);
      check_frame($sformatf("rnd%0d", k), exp_r, sb, early);
      gap = $urandom_range(0, 20);
      if ((sb && !s2) || (!sb && !s1)) gap = gap + 16;
      repeat (gap) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage of the UART, directly downstream of the baud generator. It consumes that generator's 16x-oversampling `sample` pulse and the asynchronous `rx` line. It de-serialises one frame (start bit, 5–8 data bits LSB-first, optional parity, 1–2 stop bits) and presents the byte with a one-cycle valid pulse and error flags to the UART RX FIFO/register front-end.

## Interface
- Parameters: none; oversampling ratio fixed at 16 ticks per bit.
- Reset: asynchronous, active-low; one clock.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `rx_i`  in  1  serial line, asynchronous to `clk_i`, idle high.
- `sample_i`  in  1  one-cycle tick, 16 per bit period, from the baud generator.
- `data_bits_i`  in  2  data length: 00=5, 01=6, 10=7, 11=8.
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `parity_en_i`  in  1  parity bit present. Port exists only with `UART_PARITY_EN`.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even. Port exists only with `UART_PARITY_EN`.
- `data_o`  out  8  received byte, right-aligned, unused MSBs zero; holds until the next frame completes.
- `valid_o`  out  1  one-cycle pulse when a frame completes.
- `frame_error_o`  out  1  stop bit sampled low; valid only with `valid_o`.
- `parity_error_o`  out  1  parity mismatch; valid only with `valid_o`. Port exists only with `UART_PARITY_EN`.
- `busy_o`  out  1  high while the FSM is not in IDLE.

## Operation
- **Input synchroniser.** `rx_i` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rx_s`.
- **Counters.**
  - 4-bit tick counter: advances only on `sample_i`.
  - 3-bit bit index.
  - 8-bit shift register.
- **State IDLE.**
  - `rx_s`=0 on a tick with the armed flag set → START; tick counter cleared.
  - The armed flag sets when `rx_s`=1 is seen in IDLE.
- **State START.**
  - At tick count 7 (mid-bit), `rx_s`=0 → DATA; tick counter and bit index cleared.
  - At tick count 7, `rx_s`=1 → false start; return to IDLE with no outputs.
- **State DATA.**
  - At tick count 15, sample `rx_s` into bit position `index`, then increment `index`.
  - After bit (data_bits+4) → PARITY if parity is enabled, else STOP.
- **State PARITY.** At tick 15, sample the parity bit. Error = XOR of received data bits XOR parity bit XOR `parity_odd_i`.
- **State STOP.**
  - At tick 15, sample the stop bit; `rx_s`=0 sets the frame error.
  - If `stop_bits_i`=1, sample a second stop bit 16 ticks later; either bit low sets the frame error.
  - Then: `data_o` latched, `valid_o` pulsed, FSM → IDLE.
  - On frame error, the armed flag is cleared, so a break (line held low) does not retrigger until `rx_s` returns high.
- **Configuration inputs** are sampled in IDLE at the start-bit detect and held internally for the whole frame.
- **Outputs** are registered. `frame_error_o` and `parity_error_o` are asserted only in the `valid_o` cycle; otherwise 0.

## Timing
- Reset values:
  - `data_o` = 0x00
  - `valid_o`, `frame_error_o`, `parity_error_o`, `busy_o` = 0
  - FSM = IDLE, armed flag = 1, synchroniser = 1.
- Reset mid-frame aborts the frame immediately; no `valid_o` is emitted.
- Start detect latency: up to 2 cycles (synchroniser) plus the wait for the next tick.
- `valid_o` rises in the cycle after the `sample_i` tick that samples the last stop bit.
- `sample_i` never coincides with itself on consecutive cycles (divider ≥ 1). With divider 0 the block must still function, one tick per cycle.
- `busy_o` rises the cycle after the start edge is accepted. It falls in the same cycle `valid_o` is asserted, or the cycle after a false-start reject.
- Back-to-back frames: a start bit immediately after the stop bit is accepted, because IDLE is re-entered at the stop mid-point.

## Configuration
- `UART_PARITY_EN` defined:
  - `parity_en_i`, `parity_odd_i` and `parity_error_o` ports exist.
  - The PARITY state is built.
- Not defined:
  - Those ports and the PARITY state are absent.
  - DATA → STOP directly; frames are parity-less.

## Structure
- Shared package `uart_pkg`:
  - receiver state enum (IDLE, START, DATA, PARITY, STOP)
  - data-length encoding constants
  - stop-bit encoding
  - `OVERSAMPLE = 16`
  - mid-bit tick constant (7)
- One sub-module: `uart_rx_synchronizer`, a 2-flop synchroniser with reset value 1.

## Test plan
Bench setup for all scenarios: baud divider 3 (tick every 4 cycles, 64 cycles/bit).
1. **Basic 8N1.** 8N1 frame 0xA5 → `data_o`=0xA5, one `valid_o` pulse, `frame_error_o`=0, `busy_o` low afterwards.
2. **7-bit, two stop bits.** 7 data bits, two stop bits, byte 0x5A → `data_o`=0x5A, `valid_o` after the second stop bit; the second stop driven low → `frame_error_o`=1.
3. **Glitch rejection.** 20-cycle low glitch on idle line → false start, no `valid_o`, FSM back to IDLE.
4. **Break handling.** Line held low for 2 frame times → one `valid_o` with `data_o`=0x00 and `frame_error_o`=1. No further frames until the line goes high, then 0x3C is received correctly.
5. **Parity (`UART_PARITY_EN`).** Even parity, byte 0x07 with parity bit 1 → `parity_error_o`=0; same byte with parity bit 0 → `parity_error_o`=1.
6. **Reset mid-frame.** `rst_n_i` asserted mid-frame (during DATA bit 3) → all outputs 0 immediately. The next full frame 0x81 is received correctly.
